// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-programmable clock divider.
//
// Produces a registered divided clock and a one-cycle terminal-count strobe from the
// board clock. For divisor D the output is low for D - floor(D/2) cycles, then high for
// floor(D/2) cycles. A new divisor can be written at any time. It is held pending and
// applied only at a period boundary, so no partial period is ever produced.
//
// Parameters:
//   DIV_W       width of the divisor and the phase counter
//   DEFAULT_DIV divisor loaded at reset (10 gives the legacy 5-low/5-high waveform)
//
// Ports:
//   clk        board clock; all logic runs on the rising edge
//   reset      synchronous, active-high reset
//   en         count enable; 0 freezes the phase, clk_out and the applied divisor
//   div_wr     divisor write strobe, one cycle wide
//   div_in     requested divisor, sampled when div_wr=1; values below 2 are rejected
//   clk_out    registered divided clock
//   tick       high in the last cycle of each clk_out period (only while en=1)
//   cur_div    divisor currently in effect
//   div_busy   a written divisor is pending and has not yet been applied
//   div_err    one-cycle pulse after a rejected write
//   period_cnt (only with CLK_DIV_STAT_EN) free-running count of ticks, wraps at 2^32
//
// Optional feature macro: CLK_DIV_STAT_EN (adds period_cnt).

module clk_div_gen #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             div_busy,
  output logic             div_err
`ifdef CLK_DIV_STAT_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_pend_val;
  logic             r_pending;
  logic             r_clk_out;
  logic             r_div_err;

  logic             w_wr_ok;
  logic             w_wr_bad;
  logic             w_last;
  logic             w_tick;
  logic             w_apply;
  logic [DIV_W-1:0] w_cnt_d;
  logic [DIV_W-1:0] w_cur_div_d;
  logic [DIV_W-1:0] w_pend_val_d;
  logic             w_pending_d;
  logic [DIV_W-1:0] w_low_len_d;
  logic             w_clk_out_d;

  always_comb begin
    w_wr_ok  = div_wr && (div_in >= DIV_W'(2));
    w_wr_bad = div_wr && (div_in <  DIV_W'(2));
    w_last   = (r_cnt == (r_cur_div - DIV_W'(1)));
    w_tick   = en && w_last;
    // A valid write landing in the boundary cycle is applied immediately, even with
    // nothing pending, and wins over an older pending value.
    w_apply  = w_tick && (r_pending || w_wr_ok);

    w_cnt_d      = r_cnt;
    w_cur_div_d  = r_cur_div;
    w_pend_val_d = r_pend_val;
    w_pending_d  = r_pending;

    if (w_wr_ok) begin
      w_pend_val_d = div_in;
      w_pending_d  = 1'b1;
    end

    if (en) begin
      w_cnt_d = w_last ? '0 : r_cnt + DIV_W'(1);
    end

    if (w_apply) begin
      w_cur_div_d = w_wr_ok ? div_in : r_pend_val;
      w_pending_d = 1'b0;
    end

    // clk_out is registered but must reflect the phase of the cycle it is shown in, so
    // it is computed from next-state count and divisor.
    w_low_len_d = w_cur_div_d - (w_cur_div_d >> 1);
    w_clk_out_d = (w_cnt_d >= w_low_len_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_cur_div  <= DIV_W'(DEFAULT_DIV);
      r_pend_val <= DIV_W'(DEFAULT_DIV);
      r_pending  <= 1'b0;
      r_clk_out  <= 1'b0;
      r_div_err  <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_cur_div  <= w_cur_div_d;
      r_pend_val <= w_pend_val_d;
      r_pending  <= w_pending_d;
      r_clk_out  <= w_clk_out_d;
      r_div_err  <= w_wr_bad;
    end
  end

`ifdef CLK_DIV_STAT_EN
  logic [31:0] r_period_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_period_cnt <= '0;
    end else if (w_tick) begin
      r_period_cnt <= r_period_cnt + 32'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

  assign clk_out  = r_clk_out;
  assign tick     = w_tick;
  assign cur_div  = r_cur_div;
  assign div_busy = r_pending;
  assign div_err  = r_div_err;

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

  localparam int unsigned DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             div_wr = 1'b0;
  logic [DIV_W-1:0] div_in = '0;
  logic             clk_out;
  logic             tick;
  logic [DIV_W-1:0] cur_div;
  logic             div_busy;
  logic             div_err;
`ifdef CLK_DIV_STAT_EN
  logic [31:0]      period_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: position within the current period, divisor, pending request.
  int m_pos, m_div, m_pval;
  bit m_pend, m_err;

  clk_div_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .clk_out  (clk_out),
    .tick     (tick),
    .cur_div  (cur_div),
    .div_busy (div_busy),
    .div_err  (div_err)
`ifdef CLK_DIV_STAT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model advance for one clock, using the inputs currently driven.
  task automatic model_step();
    bit ok, period_end;
    int din;
    din = int'(div_in);
    if (reset) begin
      m_pos = 0; m_div = 10; m_pend = 0; m_err = 0;
      return;
    end
    ok         = div_wr && din >= 2;
    m_err      = div_wr && din < 2;
    period_end = en && (m_pos == m_div - 1);
    if (period_end) begin
      m_pos = 0;
      if (ok) begin
        m_div = din; m_pend = 0;
      end else if (m_pend) begin
        m_div = m_pval; m_pend = 0;
      end
    end else begin
      if (en) m_pos = m_pos + 1;
      if (ok) begin
        m_pval = din; m_pend = 1;
      end
    end
  endtask

  task automatic drive(input logic e, input logic w, input int d);
    en = e; div_wr = w; div_in = DIV_W'(d);
    #1;
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    drive(1'b1, 1'b0, 0);
    adv();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 7);
    adv();
    reset = 1'b0;
    drive(1'b0, 1'b0, 0);
    checks++;
    if ({clk_out, tick, cur_div, div_busy, div_err} !== {1'b0, 1'b0, 16'd10, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got co=%b tk=%b div=%0d busy=%b err=%b want 0 0 10 0 0",
               clk_out, tick, cur_div, div_busy, div_err);
    end
  endtask

  task automatic test_default_wave();
    reset_dut();
    for (int k = 1; k <= 30; k++) begin
      drive(1'b1, 1'b0, 0);
      checks++;
      if ({clk_out, tick, cur_div} !== {1'(((k - 1) % 10) >= 5), 1'(k % 10 == 0), 16'd10}) begin
        failures++;
        $display("FAIL default_wave cycle %0d got co=%b tk=%b div=%0d want co=%b tk=%b div=10",
                 k, clk_out, tick, cur_div, ((k - 1) % 10) >= 5, k % 10 == 0);
      end
      adv();
    end
  endtask

  task automatic test_reload();
    reset_dut();
    for (int k = 0; k < 3; k++) begin drive(1'b1, 1'b0, 0); adv(); end
    drive(1'b1, 1'b1, 4);
    adv();
    for (int k = 4; k <= 9; k++) begin
      drive(1'b1, 1'b0, 0);
      checks++;
      if ({div_busy, cur_div, clk_out, tick} !== {1'b1, 16'd10, 1'(k >= 5), 1'(k == 9)}) begin
        failures++;
        $display("FAIL reload_old_period cnt %0d got busy=%b div=%0d co=%b tk=%b",
                 k, div_busy, cur_div, clk_out, tick);
      end
      adv();
    end
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 1'b0, 0);
      checks++;
      if ({div_busy, cur_div, clk_out, tick} !== {1'b0, 16'd4, 1'(j % 4 >= 2), 1'(j % 4 == 3)})
      begin
        failures++;
        $display("FAIL reload_new_period j %0d got busy=%b div=%0d co=%b tk=%b want div=4",
                 j, div_busy, cur_div, clk_out, tick);
      end
      adv();
    end
  endtask

  task automatic test_bad_write();
    reset_dut();
    drive(1'b1, 1'b1, 1);
    adv();
    drive(1'b1, 1'b1, 0);
    checks++;
    if ({div_err, div_busy} !== 2'b10) begin
      failures++;
      $display("FAIL bad_write_1 got err=%b busy=%b want err=1 busy=0", div_err, div_busy);
    end
    adv();
    drive(1'b1, 1'b0, 0);
    checks++;
    if ({div_err, div_busy} !== 2'b10) begin
      failures++;
      $display("FAIL bad_write_0 got err=%b busy=%b want err=1 busy=0", div_err, div_busy);
    end
    adv();
    drive(1'b1, 1'b0, 0);
    checks++;
    if ({div_err, div_busy, cur_div} !== {1'b0, 1'b0, 16'd10}) begin
      failures++;
      $display("FAIL bad_write_after got err=%b busy=%b div=%0d want 0 0 10",
               div_err, div_busy, cur_div);
    end
    adv();
  endtask

  task automatic test_last_wins();
    reset_dut();
    drive(1'b1, 1'b1, 7); adv();
    drive(1'b1, 1'b1, 3); adv();
    for (int k = 2; k <= 9; k++) begin drive(1'b1, 1'b0, 0); adv(); end
    drive(1'b1, 1'b0, 0);
    checks++;
    if ({cur_div, div_busy} !== {16'd3, 1'b0}) begin
      failures++;
      $display("FAIL last_wins got div=%0d busy=%b want 3 0", cur_div, div_busy);
    end
    adv(); adv();
    drive(1'b1, 1'b1, 5);
    checks++;
    if ({tick, div_busy} !== 2'b10) begin
      failures++;
      $display("FAIL boundary_write_tick got tk=%b busy=%b want 1 0", tick, div_busy);
    end
    adv();
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, 1'b0, 0);
      checks++;
      if ({cur_div, div_busy, clk_out, tick} !== {16'd5, 1'b0, 1'(j % 5 >= 3), 1'(j % 5 == 4)})
      begin
        failures++;
        $display("FAIL boundary_write_period j %0d got div=%0d busy=%b co=%b tk=%b want div=5",
                 j, cur_div, div_busy, clk_out, tick);
      end
      adv();
    end
  endtask

  task automatic test_enable_freeze();
    reset_dut();
    drive(1'b1, 1'b1, 3); adv();
    for (int k = 1; k <= 9; k++) begin drive(1'b1, 1'b0, 0); adv(); end
    drive(1'b1, 1'b0, 0); adv();
    drive(1'b1, 1'b0, 0); adv();
    // D=3 at phase 2 (high, last cycle); freeze while a new divisor is written.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'(k == 0), 2);
      checks++;
      if ({clk_out, tick, cur_div, div_busy} !== {1'b1, 1'b0, 16'd3, 1'(k != 0)}) begin
        failures++;
        $display("FAIL freeze k %0d got co=%b tk=%b div=%0d busy=%b want 1 0 3 %b",
                 k, clk_out, tick, cur_div, div_busy, k != 0);
      end
      adv();
    end
    drive(1'b1, 1'b0, 0);
    checks++;
    if ({clk_out, tick} !== 2'b11) begin
      failures++;
      $display("FAIL freeze_resume got co=%b tk=%b want 1 1", clk_out, tick);
    end
    adv();
    drive(1'b1, 1'b0, 0);
    checks++;
    if ({clk_out, tick, cur_div, div_busy} !== {1'b0, 1'b0, 16'd2, 1'b0}) begin
      failures++;
      $display("FAIL freeze_apply got co=%b tk=%b div=%0d busy=%b want 0 0 2 0",
               clk_out, tick, cur_div, div_busy);
    end
    adv();
  endtask

  task automatic test_reset_pending();
    reset_dut();
    drive(1'b1, 1'b1, 6); adv();
    for (int k = 1; k <= 5; k++) begin drive(1'b1, 1'b0, 0); adv(); end
    reset = 1'b1;
    drive(1'b1, 1'b1, 4);
    adv();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 0);
      checks++;
      if ({cur_div, div_busy, clk_out, tick} !== {16'd10, 1'b0, 1'(k >= 5), 1'(k == 9)}) begin
        failures++;
        $display("FAIL reset_pending k %0d got div=%0d busy=%b co=%b tk=%b want div=10 busy=0",
                 k, cur_div, div_busy, clk_out, tick);
      end
      adv();
    end
  endtask

  task automatic test_random();
    logic [19:0] exp, got;
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 12)));
      exp = {1'(m_pos >= m_div - m_div / 2), 1'(en && m_pos == m_div - 1), 16'(m_div),
             m_pend, m_err};
      got = {clk_out, tick, cur_div, div_busy, div_err};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random cycle %0d got co/tk/div/busy/err=%h want %h", n, got, exp);
      end
      adv();
    end
    reset = 1'b0;
  endtask

`ifdef CLK_DIV_STAT_EN
  task automatic test_stats();
    reset_dut();
    for (int k = 0; k < 30; k++) begin drive(1'b1, 1'b0, 0); adv(); end
    drive(1'b1, 1'b0, 0);
    checks++;
    if (period_cnt !== 32'd3) begin
      failures++;
      $display("FAIL stats_count got %0d want 3", period_cnt);
    end
    for (int k = 0; k < 9; k++) begin drive(1'b1, 1'b0, 0); adv(); end
    drive(1'b1, 1'b0, 0);
    force dut.r_period_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_period_cnt;
    adv();
    drive(1'b1, 1'b0, 0);
    checks++;
    if (period_cnt !== 32'd0) begin
      failures++;
      $display("FAIL stats_wrap got %h want 0", period_cnt);
    end
  endtask
`endif

  initial begin
    m_pos = 0; m_div = 10; m_pval = 10; m_pend = 0; m_err = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_default_wave();
    test_reload();
    test_bad_write();
    test_last_wins();
    test_enable_freeze();
    test_reset_pending();
    test_random();
`ifdef CLK_DIV_STAT_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
